// File: rtl/apb_pkg.sv
// Shared types for the APB register completer: FSM states, error causes,
// and sizing helpers used by the top and the register bank.
package apb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_MISALIGN = 2'd1;
  localparam logic [1:0] ERR_RO       = 2'd2;
  localparam logic [1:0] ERR_PRIV     = 2'd3;

  localparam int CNT_WIDTH  = 16;
  localparam int WCNT_WIDTH = 4;

  function automatic int strb_width(input int dw);
    return (dw + 7) / 8;
  endfunction

  function automatic int num_regs(input int aw);
    return (2 ** (aw + 1)) / 4;
  endfunction

  // The last word index is always the read-only transfer counter.
  function automatic int cnt_idx(input int aw);
    return num_regs(aw) - 1;
  endfunction

  function automatic logic [1:0] decode_err(input logic [1:0] lsb, input logic wr,
                                            input logic priv, input logic is_cnt,
                                            input logic is_ctrl);
    if (lsb != 2'b00) return ERR_MISALIGN;
    if (wr && is_cnt) return ERR_RO;
    if (wr && is_ctrl && !priv) return ERR_PRIV;
    return ERR_NONE;
  endfunction

endpackage

// File: rtl/apb_reg_bank.sv
// Read/write word storage: byte-strobed synchronous write, combinational read.
// Indices past the last stored word read as zero and ignore writes.
module apb_reg_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = 4,
  parameter int NUM_RW     = 3,
  parameter int IDX_W      = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic [IDX_W-1:0]      wr_idx_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [STRB_WIDTH-1:0] strb_i,
  input  logic [IDX_W-1:0]      rd_idx_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] regs_q [NUM_RW];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_RW; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (int'(wr_idx_i) < NUM_RW)) begin
      for (int b = 0; b < DATA_WIDTH; b++) begin
        if (strb_i[b/8]) regs_q[wr_idx_i][b] <= wdata_i[b];
      end
    end
  end

  assign rdata_o = (int'(rd_idx_i) < NUM_RW) ? regs_q[rd_idx_i] : '0;

endmodule

// File: rtl/apb_slave_regs.sv
// APB completer with a byte-strobed register bank and a 16-bit transfer counter.
// Latency 2+WAIT_STATES cycles from setup to the single-cycle ready pulse.
module apb_slave_regs
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 3,
  parameter int DATA_WIDTH  = 32,
  parameter int STRB_WIDTH  = strb_width(DATA_WIDTH),
  parameter int SEL_WIDTH   = 2,
  parameter int SEL_IDX     = 0,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH:0]   addr,
  input  logic [2:0]            prot,
  input  logic [SEL_WIDTH-1:0]  sel,
  input  logic                  enable,
  input  logic                  write,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [STRB_WIDTH-1:0] strb,
  output logic                  ready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  slv_err
);

  localparam int NUM_REGS = num_regs(ADDR_WIDTH);
  localparam int IDX_W    = ADDR_WIDTH - 1;
  localparam logic [IDX_W-1:0]      CNT_IDX = IDX_W'(cnt_idx(ADDR_WIDTH));
  localparam logic [WCNT_WIDTH-1:0] WAIT_Q  = WCNT_WIDTH'(WAIT_STATES);

  state_e                 state_q;
  logic [WCNT_WIDTH-1:0]  wcnt_q;
  logic                   ready_q;
  logic                   err_q;
  logic [DATA_WIDTH-1:0]  rdata_q;
  logic [ADDR_WIDTH:0]    addr_q;
  logic                   write_q;
  logic                   priv_q;
  logic [DATA_WIDTH-1:0]  wdata_q;
  logic [STRB_WIDTH-1:0]  strb_q;
  logic [CNT_WIDTH-1:0]   xfer_cnt_q;

  logic                   sel_me;
  logic                   setup;
  logic                   done;
  logic                   bank_we;
  logic [ADDR_WIDTH:0]    cur_addr;
  logic                   cur_write;
  logic                   cur_priv;
  logic [IDX_W-1:0]       cur_idx;
  logic [1:0]             err_code;
  logic [DATA_WIDTH-1:0]  bank_rdata;
  logic [DATA_WIDTH-1:0]  rdata_d;
  logic                   ready_d;
  logic                   err_d;
  logic                   unused_bits;

  assign sel_me      = sel[SEL_IDX];
  assign setup       = sel_me && !enable;
  assign done        = (state_q == ACCESS) && ready_q && sel_me && enable;
  assign unused_bits = ^{sel, prot[2:1]};

  // A zero-wait response is formed during setup, before the control is latched.
  always_comb begin
    cur_addr  = addr_q;
    cur_write = write_q;
    cur_priv  = priv_q;
    if (state_q == IDLE) begin
      cur_addr  = addr;
      cur_write = write;
      cur_priv  = prot[0];
    end
  end

  assign cur_idx  = cur_addr[ADDR_WIDTH:2];
  assign err_code = decode_err(cur_addr[1:0], cur_write, cur_priv,
                               cur_idx == CNT_IDX, cur_idx == '0);
  assign bank_we  = done && write_q && (err_code == ERR_NONE);

  always_comb begin
    ready_d = 1'b0;
    if (state_q == IDLE) begin
      ready_d = setup && (WAIT_Q == '0);
    end else begin
      ready_d = sel_me && enable && !ready_q && (wcnt_q == WCNT_WIDTH'(1));
    end
    err_d   = (err_code != ERR_NONE);
    rdata_d = '0;
    if (!err_d && !cur_write) begin
      rdata_d = (cur_idx == CNT_IDX) ? DATA_WIDTH'(xfer_cnt_q) : bank_rdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      wcnt_q     <= '0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      addr_q     <= '0;
      write_q    <= 1'b0;
      priv_q     <= 1'b0;
      wdata_q    <= '0;
      strb_q     <= '0;
      xfer_cnt_q <= '0;
    end else begin
      ready_q <= ready_d;
      err_q   <= ready_d && err_d;
      rdata_q <= ready_d ? rdata_d : '0;
      case (state_q)
        IDLE: begin
          if (setup) begin
            addr_q  <= addr;
            write_q <= write;
            priv_q  <= prot[0];
            wdata_q <= wdata;
            strb_q  <= strb;
            wcnt_q  <= WAIT_Q;
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          // Losing sel before completion abandons the transfer silently.
          if (!sel_me || ready_q) begin
            state_q <= IDLE;
            if (done) xfer_cnt_q <= xfer_cnt_q + 1'b1;
          end else if (enable && (wcnt_q != '0)) begin
            wcnt_q <= wcnt_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready   = ready_q;
  assign rdata   = rdata_q;
  assign slv_err = err_q;

  apb_reg_bank #(
    .DATA_WIDTH(DATA_WIDTH),
    .STRB_WIDTH(STRB_WIDTH),
    .NUM_RW    (NUM_REGS - 1),
    .IDX_W     (IDX_W)
  ) u_bank (
    .clk_i   (clk),
    .rst_i   (reset),
    .we_i    (bank_we),
    .wr_idx_i(addr_q[ADDR_WIDTH:2]),
    .wdata_i (wdata_q),
    .strb_i  (strb_q),
    .rd_idx_i(cur_idx),
    .rdata_o (bank_rdata)
  );

endmodule

// File: tb/tb_apb_slave_regs.sv
// Three completers on one APB bus (wait states 1, 0, 3 on sel bits 0, 1, 2),
// checked against a word/byte-level model of the register map.
module tb_apb_slave_regs;

  localparam int NDUT = 3;
  localparam int WS_A = 1;
  localparam int WS_B = 0;
  localparam int WS_C = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  addr;
  logic [2:0]  prot;
  logic [2:0]  sel;
  logic        enable;
  logic        write;
  logic [31:0] wdata;
  logic [3:0]  strb;
  logic [2:0]  rdy;
  logic [2:0]  serr;
  logic [31:0] rdat [NDUT];

  int n_tests = 0;
  int n_fail  = 0;
  int ws_of [NDUT] = '{WS_A, WS_B, WS_C};

  always #5 clk = ~clk;

  apb_slave_regs #(.ADDR_WIDTH(3), .DATA_WIDTH(32), .STRB_WIDTH(4), .SEL_WIDTH(3),
                   .SEL_IDX(0), .WAIT_STATES(WS_A)) u_a (
    .clk(clk), .reset(reset), .addr(addr), .prot(prot), .sel(sel), .enable(enable),
    .write(write), .wdata(wdata), .strb(strb), .ready(rdy[0]), .rdata(rdat[0]),
    .slv_err(serr[0]));

  apb_slave_regs #(.ADDR_WIDTH(3), .DATA_WIDTH(32), .STRB_WIDTH(4), .SEL_WIDTH(3),
                   .SEL_IDX(1), .WAIT_STATES(WS_B)) u_b (
    .clk(clk), .reset(reset), .addr(addr), .prot(prot), .sel(sel), .enable(enable),
    .write(write), .wdata(wdata), .strb(strb), .ready(rdy[1]), .rdata(rdat[1]),
    .slv_err(serr[1]));

  apb_slave_regs #(.ADDR_WIDTH(3), .DATA_WIDTH(32), .STRB_WIDTH(4), .SEL_WIDTH(3),
                   .SEL_IDX(2), .WAIT_STATES(WS_C)) u_c (
    .clk(clk), .reset(reset), .addr(addr), .prot(prot), .sel(sel), .enable(enable),
    .write(write), .wdata(wdata), .strb(strb), .ready(rdy[2]), .rdata(rdat[2]),
    .slv_err(serr[2]));

  // Reference: three RW words and one counter per completer.
  logic [31:0] mregs [NDUT][3];
  logic [15:0] mcnt  [NDUT];

  task automatic model_reset();
    for (int d = 0; d < NDUT; d++) begin
      for (int i = 0; i < 3; i++) mregs[d][i] = 32'h0;
      mcnt[d] = 16'h0;
    end
  endtask

  task automatic model_xfer(input int d, input logic [3:0] a, input logic wr,
                            input logic [31:0] wd, input logic [3:0] st, input logic [2:0] pr,
                            output logic [31:0] rd, output logic er);
    int idx;
    logic [31:0] cur;
    idx = int'(a) / 4;
    er  = (int'(a) % 4 != 0) || (wr && idx == 3) || (wr && idx == 0 && !pr[0]);
    rd  = 32'h0;
    if (!er && !wr) rd = (idx == 3) ? {16'h0, mcnt[d]} : mregs[d][idx];
    if (!er && wr) begin
      cur = mregs[d][idx];
      for (int b = 0; b < 4; b++) if (st[b]) cur[8*b +: 8] = wd[8*b +: 8];
      mregs[d][idx] = cur;
    end
    mcnt[d] = mcnt[d] + 16'd1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, want);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    sel    = 3'b000;
    enable = 1'b0;
  endtask

  task automatic do_xfer(input int d, input logic [3:0] a, input logic wr,
                         input logic [31:0] wd, input logic [3:0] st, input logic [2:0] pr,
                         output logic [31:0] rd, output logic er, output int lat,
                         output logic pre);
    logic [2:0] onehot;
    onehot = 3'b001 << d;
    @(negedge clk);
    sel = onehot; enable = 1'b0; addr = a; write = wr; wdata = wd; strb = st; prot = pr;
    #1 pre = rdy[d];
    @(negedge clk);
    enable = 1'b1;
    lat = 2;
    while (rdy[d] !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    rd = rdat[d];
    er = serr[d];
    chk($sformatf("xsel_d%0d", d), 32'(rdy & ~onehot), 32'h0);
  endtask

  typedef struct {
    logic [3:0]  a;
    logic        wr;
    logic [31:0] wd;
    logic [3:0]  st;
    logic [2:0]  pr;
    logic [31:0] exp_rd;
    logic        exp_er;
  } vec_t;

  vec_t tbl [17];

  initial begin
    logic [31:0] rd, erd, rwd;
    logic        er, eer, pre, seen, rwr;
    logic [3:0]  ra, rst_b;
    logic [2:0]  rpr;
    int          lat, rdut;

    reset = 1'b1; sel = 3'b000; enable = 1'b0; write = 1'b0;
    addr = 4'h0; wdata = 32'h0; strb = 4'h0; prot = 3'b000;
    model_reset();

    tbl[0]  = '{4'h4, 1'b1, 32'hDEADBEEF, 4'hF, 3'b001, 32'h0,        1'b0};
    tbl[1]  = '{4'h4, 1'b0, 32'h0,        4'hF, 3'b001, 32'hDEADBEEF, 1'b0};
    tbl[2]  = '{4'h8, 1'b1, 32'h11223344, 4'hF, 3'b001, 32'h0,        1'b0};
    tbl[3]  = '{4'h8, 1'b1, 32'hAABBCCDD, 4'h5, 3'b001, 32'h0,        1'b0};
    tbl[4]  = '{4'hC, 1'b1, 32'hFFFFFFFF, 4'hF, 3'b001, 32'h0,        1'b1};
    tbl[5]  = '{4'hC, 1'b0, 32'h0,        4'hF, 3'b001, 32'h5,        1'b0};
    tbl[6]  = '{4'h8, 1'b0, 32'h0,        4'hF, 3'b000, 32'h11BB33DD, 1'b0};
    tbl[7]  = '{4'h0, 1'b1, 32'h12345678, 4'hF, 3'b000, 32'h0,        1'b1};
    tbl[8]  = '{4'h0, 1'b0, 32'h0,        4'hF, 3'b000, 32'h0,        1'b0};
    tbl[9]  = '{4'h0, 1'b1, 32'h12345678, 4'hF, 3'b001, 32'h0,        1'b0};
    tbl[10] = '{4'h0, 1'b0, 32'h0,        4'hF, 3'b000, 32'h12345678, 1'b0};
    tbl[11] = '{4'h6, 1'b0, 32'h0,        4'hF, 3'b001, 32'h0,        1'b1};
    tbl[12] = '{4'h4, 1'b1, 32'h0BADF00D, 4'h0, 3'b001, 32'h0,        1'b0};
    tbl[13] = '{4'h4, 1'b0, 32'h0,        4'hF, 3'b001, 32'hDEADBEEF, 1'b0};
    tbl[14] = '{4'h5, 1'b1, 32'h0BADF00D, 4'hF, 3'b001, 32'h0,        1'b1};
    tbl[15] = '{4'h4, 1'b0, 32'h0,        4'hF, 3'b001, 32'hDEADBEEF, 1'b0};
    tbl[16] = '{4'hC, 1'b0, 32'h0,        4'hF, 3'b001, 32'h10,       1'b0};

    repeat (3) @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      chk($sformatf("reset_ready_d%0d", d), 32'(rdy[d]), 32'h0);
      chk($sformatf("reset_rdata_d%0d", d), rdat[d], 32'h0);
      chk($sformatf("reset_err_d%0d", d), 32'(serr[d]), 32'h0);
    end
    reset = 1'b0;

    for (int i = 0; i < 17; i++) begin
      do_xfer(0, tbl[i].a, tbl[i].wr, tbl[i].wd, tbl[i].st, tbl[i].pr, rd, er, lat, pre);
      idle();
      model_xfer(0, tbl[i].a, tbl[i].wr, tbl[i].wd, tbl[i].st, tbl[i].pr, erd, eer);
      chk($sformatf("tbl%0d_err", i), 32'(er), 32'(tbl[i].exp_er));
      chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
      chk($sformatf("tbl%0d_latency", i), 32'(lat), 32'(2 + WS_A));
    end

    // Reset during the wait state of a write: write must not land.
    @(negedge clk);
    sel = 3'b001; enable = 1'b0; addr = 4'h4; write = 1'b1;
    wdata = 32'hCAFEF00D; strb = 4'hF; prot = 3'b001;
    @(negedge clk);
    enable = 1'b1;
    reset  = 1'b1;
    #1;
    chk("rst_wait_ready", 32'(rdy[0]), 32'h0);
    chk("rst_wait_err", 32'(serr[0]), 32'h0);
    @(negedge clk);
    reset = 1'b0; sel = 3'b000; enable = 1'b0;
    model_reset();
    do_xfer(0, 4'h4, 1'b0, 32'h0, 4'hF, 3'b001, rd, er, lat, pre);
    idle();
    model_xfer(0, 4'h4, 1'b0, 32'h0, 4'hF, 3'b001, erd, eer);
    chk("rst_wait_reg4", rd, erd);
    do_xfer(0, 4'hC, 1'b0, 32'h0, 4'hF, 3'b001, rd, er, lat, pre);
    idle();
    model_xfer(0, 4'hC, 1'b0, 32'h0, 4'hF, 3'b001, erd, eer);
    chk("rst_wait_cnt", rd, erd);

    // Reset while an error response is on the bus: outputs drop at once.
    @(negedge clk);
    sel = 3'b001; enable = 1'b0; addr = 4'h6; write = 1'b0; prot = 3'b001;
    @(negedge clk);
    enable = 1'b1;
    lat = 2;
    while (rdy[0] !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("rst_ready_pre_ready", 32'(rdy[0]), 32'h1);
    chk("rst_ready_pre_err", 32'(serr[0]), 32'h1);
    reset = 1'b1;
    #1;
    chk("rst_ready_ready", 32'(rdy[0]), 32'h0);
    chk("rst_ready_err", 32'(serr[0]), 32'h0);
    chk("rst_ready_rdata", rdat[0], 32'h0);
    @(negedge clk);
    reset = 1'b0; sel = 3'b000; enable = 1'b0;
    model_reset();

    // Zero-wait back-to-back reads: ready every second cycle.
    do_xfer(1, 4'h4, 1'b1, 32'h5A5A1234, 4'hF, 3'b001, rd, er, lat, pre);
    idle();
    model_xfer(1, 4'h4, 1'b1, 32'h5A5A1234, 4'hF, 3'b001, erd, eer);
    chk("b2b_wr_err", 32'(er), 32'(eer));
    for (int k = 0; k < 4; k++) begin
      do_xfer(1, (k == 3) ? 4'hC : 4'h4, 1'b0, 32'h0, 4'hF, 3'b000, rd, er, lat, pre);
      model_xfer(1, (k == 3) ? 4'hC : 4'h4, 1'b0, 32'h0, 4'hF, 3'b000, erd, eer);
      chk($sformatf("b2b%0d_gap", k), 32'(pre), 32'h0);
      chk($sformatf("b2b%0d_latency", k), 32'(lat), 32'd2);
      chk($sformatf("b2b%0d_rdata", k), rd, erd);
    end
    idle();

    // sel dropped mid-access with 3 wait states: no ready, no write, no count.
    do_xfer(2, 4'h8, 1'b1, 32'h13572468, 4'hF, 3'b001, rd, er, lat, pre);
    idle();
    model_xfer(2, 4'h8, 1'b1, 32'h13572468, 4'hF, 3'b001, erd, eer);
    @(negedge clk);
    sel = 3'b100; enable = 1'b0; addr = 4'h8; write = 1'b1;
    wdata = 32'h77777777; strb = 4'hF; prot = 3'b001;
    @(negedge clk);
    enable = 1'b1;
    seen = rdy[2];
    @(negedge clk);
    seen |= rdy[2];
    @(negedge clk);
    seen |= rdy[2];
    sel = 3'b000; enable = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen |= rdy[2];
    end
    chk("seldrop_no_ready", 32'(seen), 32'h0);
    do_xfer(2, 4'h8, 1'b0, 32'h0, 4'hF, 3'b001, rd, er, lat, pre);
    idle();
    model_xfer(2, 4'h8, 1'b0, 32'h0, 4'hF, 3'b001, erd, eer);
    chk("seldrop_reg8", rd, erd);
    do_xfer(2, 4'hC, 1'b0, 32'h0, 4'hF, 3'b001, rd, er, lat, pre);
    idle();
    model_xfer(2, 4'hC, 1'b0, 32'h0, 4'hF, 3'b001, erd, eer);
    chk("seldrop_cnt", rd, erd);

    for (int i = 0; i < 80; i++) begin
      rdut  = $urandom_range(0, NDUT - 1);
      ra    = 4'($urandom_range(0, 15));
      rwr   = 1'($urandom_range(0, 1));
      rwd   = $urandom;
      rst_b = 4'($urandom_range(0, 15));
      rpr   = 3'($urandom_range(0, 7));
      do_xfer(rdut, ra, rwr, rwd, rst_b, rpr, rd, er, lat, pre);
      if ($urandom_range(0, 1) == 1) idle();
      model_xfer(rdut, ra, rwr, rwd, rst_b, rpr, erd, eer);
      chk($sformatf("rnd%0d_d%0d_a%h_err", i, rdut, ra), 32'(er), 32'(eer));
      chk($sformatf("rnd%0d_d%0d_a%h_rdata", i, rdut, ra), rd, erd);
      chk($sformatf("rnd%0d_d%0d_latency", i, rdut), 32'(lat), 32'(2 + ws_of[rdut]));
    end
    idle();

    for (int d = 0; d < NDUT; d++) begin
      do_xfer(d, 4'hC, 1'b0, 32'h0, 4'hF, 3'b001, rd, er, lat, pre);
      idle();
      model_xfer(d, 4'hC, 1'b0, 32'h0, 4'hF, 3'b001, erd, eer);
      chk($sformatf("final_cnt_d%0d", d), rd, erd);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
